// File: rtl/gsim_pkg.sv
// Shared widths, banded-matrix coefficients and FSM encoding for the GSIM
// matrix-vector multiply (b = M*x).
package gsim_pkg;

  localparam int N      = 16;  // vector length
  localparam int X_W    = 32;  // Q16.16 solution element
  localparam int ACC_W  = 38;  // Q22.16 row accumulator
  localparam int B_W    = 16;  // integer b word
  localparam int FRAC_W = 16;  // fractional bits of x and the accumulator
  localparam int TAPS   = 7;   // band width: offsets -3..+3

  // Symmetric band coefficients: diagonal, offset 1, offset 2, offset 3.
  localparam int COEF_D = 20;
  localparam int COEF_1 = -13;
  localparam int COEF_2 = 6;
  localparam int COEF_3 = -1;

  typedef enum logic {
    LOAD = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/gsim_row_mac.sv
// Combinational 7-tap shift-add for one row of the banded matrix.
// Tap j holds x[i+j-3]; disabled taps (column outside the vector) add zero.
module gsim_row_mac
  import gsim_pkg::*;
(
  input  logic [TAPS-1:0][X_W-1:0]  taps,
  input  logic [TAPS-1:0]           tap_en,
  output logic signed [ACC_W-1:0]   sum
);

  logic signed [ACC_W-1:0] ext [TAPS];

  function automatic logic signed [ACC_W-1:0] mul20(input logic signed [ACC_W-1:0] v);
    return (v <<< 4) + (v <<< 2);
  endfunction

  function automatic logic signed [ACC_W-1:0] mul13(input logic signed [ACC_W-1:0] v);
    return (v <<< 3) + (v <<< 2) + v;
  endfunction

  function automatic logic signed [ACC_W-1:0] mul6(input logic signed [ACC_W-1:0] v);
    return (v <<< 2) + (v <<< 1);
  endfunction

  // Sign-extend enabled taps to the accumulator width, zero the rest.
  always_comb begin
    for (int j = 0; j < TAPS; j++) begin
      ext[j] = '0;
      if (tap_en[j]) begin
        ext[j] = {{(ACC_W-X_W){taps[j][X_W-1]}}, taps[j]};
      end
    end
  end

  // Band sum: -1, 6, -13, 20, -13, 6, -1. 60*2^31 < 2^37, so no overflow.
  always_comb begin
    sum = mul20(ext[3])
        - mul13(ext[2]) - mul13(ext[4])
        + mul6(ext[1])  + mul6(ext[5])
        - ext[0]        - ext[6];
  end

endmodule

// File: rtl/gsim_mvm.sv
// GSIM matrix-vector multiply: loads x[0..15], then streams b[0..15] = M*x,
// one registered row per cycle, rounded to integer with saturation.
module gsim_mvm
  import gsim_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_en,
  input  logic signed [X_W-1:0]   x_in,
  output logic                    busy,
  output logic                    out_valid,
  output logic signed [B_W-1:0]   b_out,
  output logic signed [ACC_W-1:0] b_full,
  output logic                    sat
);

  localparam int R_W = ACC_W - FRAC_W;
  localparam logic [3:0] LAST = 4'(N - 1);
  localparam logic signed [R_W-1:0] R_MAX = R_W'((2 ** (B_W - 1)) - 1);
  localparam logic signed [R_W-1:0] R_MIN = R_W'(-(2 ** (B_W - 1)));
  localparam logic signed [B_W-1:0] B_MAX = {1'b0, {(B_W-1){1'b1}}};
  localparam logic signed [B_W-1:0] B_MIN = {1'b1, {(B_W-1){1'b0}}};

  state_t state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] row;
  logic [3:0] sel;
  logic load_wr, load_done, emit;
  logic signed [X_W-1:0] x_mem [N];
  logic [5:0] col [TAPS];
  logic [TAPS-1:0][X_W-1:0] taps;
  logic [TAPS-1:0] tap_en;
  logic signed [ACC_W-1:0] acc;
  logic signed [R_W-1:0] rnd;

  // Round half up: add 0.5 then arithmetic shift out the fraction.
  function automatic logic signed [R_W-1:0] round_q(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] t;
    t = v + ACC_W'(2 ** (FRAC_W - 1));
    return t[ACC_W-1:FRAC_W];
  endfunction

  function automatic logic signed [B_W-1:0] clip(input logic signed [R_W-1:0] r);
    if (r > R_MAX) return B_MAX;
    else if (r < R_MIN) return B_MIN;
    else return r[B_W-1:0];
  endfunction

  function automatic logic is_clipped(input logic signed [R_W-1:0] r);
    return (r > R_MAX) || (r < R_MIN);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    load_wr   = 1'b0;
    load_done = 1'b0;
    emit      = 1'b0;
    case (state)
      LOAD: begin
        if (in_en) begin
          load_wr = 1'b1;
          if (cnt == LAST) begin
            load_done = 1'b1;
            emit      = 1'b1;
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        emit = (row != LAST);
        if (row == LAST) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // row is the row currently on the outputs; the next one is computed from
  // row+1. Row 0 is produced on the load-done edge: it only needs x[0..3],
  // which are already in memory while x[15] is being written.
  always_comb begin
    sel = (state == CALC) ? row + 4'd1 : 4'd0;
    for (int j = 0; j < TAPS; j++) begin
      col[j]    = {2'b00, sel} + 6'(j) - 6'd3;
      tap_en[j] = (col[j][5:4] == 2'b00);
      taps[j]   = x_mem[col[j][3:0]];
    end
  end

  gsim_row_mac u_row_mac (
    .taps   (taps),
    .tap_en (tap_en),
    .sum    (acc)
  );

  always_comb rnd = round_q(acc);

  // Control counters, busy and out_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      row       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= emit;
      if (load_wr) cnt <= cnt + 4'd1;
      if (load_done) begin
        row  <= '0;
        busy <= 1'b1;
      end else if (state == CALC) begin
        if (row == LAST) begin
          busy <= 1'b0;
          cnt  <= '0;
        end else begin
          row <= row + 4'd1;
        end
      end
    end
  end

  // Vector storage; never read before a full reload, so no reset.
  always_ff @(posedge clk) begin
    if (load_wr) x_mem[cnt] <= x_in;
  end

  // Row output register; holds its value between rows.
  always_ff @(posedge clk) begin
    if (reset) begin
      b_full <= '0;
      b_out  <= '0;
      sat    <= 1'b0;
    end else if (emit) begin
      b_full <= acc;
      b_out  <= clip(rnd);
      sat    <= is_clipped(rnd);
    end
  end

endmodule

// File: tb/tb_gsim_mvm.sv
// Directed bench for gsim_mvm: hand-computed row results for several vectors,
// saturation in both directions, in_en gaps, in_en during CALC, resets.
module tb_gsim_mvm;

  logic clk = 1'b0;
  logic reset;
  logic in_en;
  logic [31:0] x_in;
  logic busy;
  logic out_valid;
  logic signed [15:0] b_out;
  logic signed [37:0] b_full;
  logic sat;

  int total = 0;
  int passed = 0;
  int eb [16];
  bit es [16];
  logic signed [37:0] full_obs [16];
  logic [31:0] xv [16];

  always #5 clk = ~clk;

  gsim_mvm #(.N(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .busy      (busy),
    .out_valid (out_valid),
    .b_out     (b_out),
    .b_full    (b_full),
    .sat       (sat)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Drives xv; first word goes out at the current negedge.
  task automatic load(input bit gap);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      in_en = 1'b1;
      x_in  = xv[k];
      if (gap && k != 15) begin
        @(negedge clk);
        in_en = 1'b0;
        x_in  = 32'hDEAD0000;
      end
    end
  endtask

  // Called at the negedge right after the 16th word's edge.
  task automatic rows(input string tag);
    for (int r = 0; r < 16; r++) begin
      if (r > 0) @(negedge clk);
      chk($sformatf("%s valid r%0d", tag, r), out_valid, 1);
      chk($sformatf("%s b_out r%0d", tag, r), b_out, eb[r]);
      chk($sformatf("%s sat r%0d", tag, r), sat, es[r]);
      chk($sformatf("%s busy r%0d", tag, r), busy, 1);
      full_obs[r] = b_full;
    end
    @(negedge clk);
    chk($sformatf("%s valid end", tag), out_valid, 0);
    chk($sformatf("%s busy end", tag), busy, 0);
    chk($sformatf("%s b_out hold", tag), b_out, eb[15]);
  endtask

  task automatic set_ones();
    for (int k = 0; k < 16; k++) begin
      xv[k] = 32'h00010000;
      eb[k] = 4;
      es[k] = 1'b0;
    end
    eb[0] = 12; eb[1] = -1; eb[2] = 5;
    eb[13] = 5; eb[14] = -1; eb[15] = 12;
  endtask

  task automatic set_impulse();
    for (int k = 0; k < 16; k++) begin
      xv[k] = 32'h0;
      eb[k] = 0;
      es[k] = 1'b0;
    end
    xv[0] = 32'h00010000;
    eb[0] = 20; eb[1] = -13; eb[2] = 6; eb[3] = -1;
  endtask

  task automatic set_half();
    for (int k = 0; k < 16; k++) begin
      xv[k] = 32'h0;
      eb[k] = 0;
      es[k] = 1'b0;
    end
    xv[0] = 32'h00008000;
    eb[0] = 10; eb[1] = -6; eb[2] = 3; eb[3] = 0;
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    x_in  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst b_out", b_out, 0);
    chk("rst b_full", b_full, 0);
    chk("rst sat", sat, 0);
    reset = 1'b0;
    @(negedge clk);

    // All ones, contiguous in_en.
    set_ones();
    load(1'b0);
    @(negedge clk);
    in_en = 1'b0;
    rows("ones");
    chk("ones full r0", full_obs[0], 64'sd786432);
    chk("ones full r1", full_obs[1], -64'sd65536);

    // Impulse, loaded on the very first LOAD cycle after row 15.
    set_impulse();
    load(1'b0);
    @(negedge clk);
    in_en = 1'b0;
    rows("imp");

    // Partial load aborted by reset, then a clean 0.5 impulse.
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      in_en = 1'b1;
      x_in  = 32'h00030000;
    end
    @(negedge clk);
    in_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midload rst busy", busy, 0);
    chk("midload rst valid", out_valid, 0);
    set_half();
    load(1'b0);
    @(negedge clk);
    in_en = 1'b0;
    rows("half");
    chk("half full r0", full_obs[0], 64'sd655360);
    chk("half full r1", full_obs[1], -64'sd425984);
    chk("half full r3", full_obs[3], -64'sd32768);

    // Positive saturation.
    for (int k = 0; k < 16; k++) begin
      xv[k] = 32'h7FFF0000;
      eb[k] = 32767;
      es[k] = 1'b1;
    end
    eb[1] = -32767; es[1] = 1'b0;
    eb[14] = -32767; es[14] = 1'b0;
    @(negedge clk);
    load(1'b0);
    @(negedge clk);
    in_en = 1'b0;
    rows("satp");
    chk("satp full r3", full_obs[3], 64'sd8589672448);

    // Negative saturation (and positive clip on the -1 rows).
    for (int k = 0; k < 16; k++) begin
      xv[k] = 32'h80000000;
      eb[k] = -32768;
      es[k] = 1'b1;
    end
    eb[1] = 32767;
    eb[14] = 32767;
    @(negedge clk);
    load(1'b0);
    @(negedge clk);
    in_en = 1'b0;
    rows("satn");

    // in_en every other cycle.
    set_ones();
    @(negedge clk);
    load(1'b1);
    @(negedge clk);
    in_en = 1'b0;
    rows("gap");

    // in_en held high with junk data through CALC.
    set_ones();
    @(negedge clk);
    load(1'b0);
    @(negedge clk);
    in_en = 1'b1;
    x_in  = 32'h12340000;
    rows("hold");
    in_en = 1'b0;
    set_impulse();
    @(negedge clk);
    load(1'b0);
    @(negedge clk);
    in_en = 1'b0;
    rows("posthold");

    // Reset while row 5 is on the outputs.
    set_ones();
    @(negedge clk);
    load(1'b0);
    @(negedge clk);
    in_en = 1'b0;
    for (int r = 0; r < 6; r++) begin
      if (r > 0) @(negedge clk);
      chk($sformatf("abort b_out r%0d", r), b_out, eb[r]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort b_out", b_out, 0);
    chk("abort b_full", b_full, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort quiet", out_valid, 0);
    end
    set_half();
    load(1'b0);
    @(negedge clk);
    in_en = 1'b0;
    rows("reload");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
